// File: rtl/ni_flit_fifo_pkg.sv
// Shared types for the NI flit buffer: per-cycle operation encoding used
// by the occupancy bookkeeping.
package ni_flit_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/ni_fifo_ptr.sv
// Single circular-buffer pointer; wraps from DEPTH-1 back to 0 so non-power-
// of-two depths never address past the storage array.
module ni_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr <= '0;
    else if (advance) ptr <= (ptr == LAST) ? '0 : ptr + ONE;
  end

endmodule

// File: rtl/ni_flit_fifo.sv
// Credit-flow-controlled FWFT flit buffer for the network interface. Returns
// one registered credit per popped flit and flags overflow stickily.
module ni_flit_fifo
  import ni_flit_fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] flit_in,
  input  logic             flit_valid_in,
  output logic             credit_out,
  output logic [DSIZE-1:0] flit_out,
  output logic             flit_valid_out,
  input  logic             flit_ready_in,
  output logic [PTR_W:0]   count,
  output logic             overflow_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, pop, push, drop;
  fifo_op_e         op;

  assign flit_valid_out = (count != '0);
  assign full           = (count == FULL_CNT);
  assign pop            = flit_valid_out & flit_ready_in;
  // A full buffer still accepts when the head retires in the same cycle.
  assign push           = flit_valid_in & (~full | pop);
  assign drop           = flit_valid_in & full & ~pop;
  assign op             = fifo_op(push, pop);
  assign flit_out       = mem[rd_ptr];

  ni_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (push),
    .ptr     (wr_ptr)
  );

  ni_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (pop),
    .ptr     (rd_ptr)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                 mem[i] <= '0;
      else if (push && wr_ptr == PTR_W'(i))     mem[i] <= flit_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case (op)
        OP_PUSH: count <= count + ONE;
        OP_POP:  count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_out   <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      credit_out <= pop;
      if (drop) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ni_flit_fifo.sv
// Randomized and directed checks of ni_flit_fifo against a queue-based model.
module tb_ni_flit_fifo;
  localparam int DSIZE = 32;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DSIZE-1:0] flit_in = '0;
  logic             flit_valid_in = 1'b0;
  logic             flit_ready_in = 1'b0;
  logic             credit_out;
  logic [DSIZE-1:0] flit_out;
  logic             flit_valid_out;
  logic [PTR_W:0]   count;
  logic             overflow_err;

  ni_flit_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .credit_out     (credit_out),
    .flit_out       (flit_out),
    .flit_valid_out (flit_valid_out),
    .flit_ready_in  (flit_ready_in),
    .count          (count),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DSIZE-1:0] q[$];
  bit exp_ovf    = 1'b0;
  bit exp_credit = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("valid", 64'(flit_valid_out), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    if (q.size() != 0) chk("flit_out", 64'(flit_out), 64'(q[0]));
    chk("credit", 64'(credit_out), 64'(exp_credit));
    chk("overflow", 64'(overflow_err), 64'(exp_ovf));
  endtask

  // One clock cycle: drive, check pre-edge state, advance model across the edge.
  task automatic cyc(input bit vin, input logic [DSIZE-1:0] din, input bit rdy);
    bit pop, full;
    flit_valid_in = vin;
    flit_in       = din;
    flit_ready_in = rdy;
    @(negedge clk);
    check_outs();
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (vin) begin
      if (!full || pop) q.push_back(din);
      else              exp_ovf = 1'b1;
    end
    exp_credit = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flit_valid_in = 1'b0;
    flit_ready_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(flit_valid_out), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_credit", 64'(credit_out), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_flit_out", 64'(flit_out), 64'd0);
    q.delete();
    exp_ovf    = 1'b0;
    exp_credit = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    do_reset();

    // idle, then a single flit
    cyc(0, '0, 0);
    cyc(1, 32'hA1, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);

    // fill, then drain with back-to-back credits
    for (int i = 1; i <= 4; i++) cyc(1, DSIZE'(i), 0);
    for (int i = 0; i < 4; i++)  cyc(0, '0, 1);
    cyc(0, '0, 0);

    // overflow: dropped flit never surfaces, error is sticky
    for (int i = 1; i <= 4; i++) cyc(1, DSIZE'(32'h10 + i), 0);
    cyc(1, 32'h55, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    for (int i = 0; i < 5; i++)  cyc(0, '0, 1);
    cyc(0, '0, 0);
    do_reset();

    // full-occupancy streaming with pointer wrap
    for (int i = 1; i <= 4; i++)  cyc(1, DSIZE'(32'h20 + i), 0);
    for (int i = 0; i < 10; i++)  cyc(1, DSIZE'(32'h30 + i), 1);
    for (int i = 0; i < 5; i++)   cyc(0, '0, 1);

    // ready while empty does nothing
    for (int i = 0; i < 5; i++)   cyc(0, '0, 1);

    // reset mid-stream with count=3 and a credit pending
    for (int i = 1; i <= 4; i++)  cyc(1, DSIZE'(32'h40 + i), 0);
    cyc(0, '0, 1);
    do_reset();
    cyc(1, 32'h77, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 1);

    // random traffic, reset halfway through
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cyc(($urandom_range(0, 3) != 0), DSIZE'($urandom), ($urandom_range(0, 2) != 0));
    end
    cyc(0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
